glitch_sequencer: RTL and testbench
===================================

Name: glitch_sequencer

Overview:
- Consumes 48-bit glitch descriptors from the settings FIFO filled by the Wishbone register block, one per attempt.
- For each descriptor it optionally resets the target, waits for the target trigger, counts the programmed delay, then drives glitch_en for the programmed width, repeating for a programmed pulse count.
- Sits between the FIFO read side and the clock-mux/glitch core, all in the target clock domain.

Parameters:
- RST_CYCLES, 16, number of cycles rst_o is held high when a descriptor requests a target reset.
- GAP_CYCLES, 8, idle cycles between repeated pulses; must be ≥1.
- ARM_TIMEOUT, 1000000, maximum cycles spent waiting for the trigger before abandoning the descriptor; 0 disables the timeout.
- TMO_W, 20, width of the timeout counter; must satisfy 2^TMO_W > ARM_TIMEOUT.

Ports:
- clk_i  in  1  target-domain clock; same net as the FIFO read clock.
- rst_ni  in  1  synchronous, active-low reset.
- fifo_q  in  48  FIFO read data, valid in the cycle after fifo_re.
- fifo_empty  in  1  FIFO empty flag.
- fifo_re  out  1  FIFO read strobe, a single-cycle pulse.
- trig  in  1  single-cycle trigger pulse from the edge detector (board ready).
- abort  in  1  synchronous abort request.
- rst_o  out  1  target reset output.
- glitch_en  out  1  high while a glitch pulse is active.
- delay_en  out  1  high while the delay is being counted.
- ready  out  1  high only in IDLE with fifo_empty high.
- busy  out  1  high in any state other than IDLE.
- timeout  out  1  sticky flag; set on arm timeout, cleared when the next descriptor is fetched.

Behaviour:
- Descriptor fields:
  - [23:0] delay (cycles);
  - [39:24] width (cycles, 0 treated as 1);
  - [46:40] repeat count, giving pulses = count+1;
  - [47] rst_first.
- Reset (rst_ni low at a clock edge):
  - all outputs go to 0;
  - state goes to IDLE;
  - all counters clear;
  - timeout clears.
  - Reset mid-operation drops glitch_en and rst_o on that same edge.
- IDLE:
  - if fifo_empty is low, pulse fifo_re for one cycle and go to FETCH;
  - otherwise stay in IDLE;
  - ready = fifo_empty.
- FETCH (one cycle):
  - register fifo_q into the descriptor registers;
  - clear timeout;
  - go to RST if rst_first, else go to ARM.
- RST:
  - rst_o is high for exactly RST_CYCLES cycles;
  - then go to ARM.
- ARM:
  - wait for trig;
  - a trig arriving during RST or FETCH is ignored.
  - On trig:
    - if delay = 0, go directly to GLITCH, so glitch_en rises on the cycle after trig;
    - otherwise go to DELAY.
  - When the timeout counter reaches ARM_TIMEOUT, set timeout and go to IDLE without pulsing.
- DELAY:
  - delay_en is high;
  - the down-counter starts at delay-1;
  - go to GLITCH when the counter reaches 0.
  - Total from trig to glitch_en rising = delay+1 cycles.
- GLITCH:
  - glitch_en is high for exactly max(width,1) cycles.
  - When done, if the pulse counter is less than count, go to GAP; else go to IDLE.
- GAP:
  - all outputs low for GAP_CYCLES cycles;
  - then go to GLITCH and increment the pulse counter.
- Output timing: rst_o, glitch_en and delay_en are registered, decoded from the next state, glitch-free, and mutually exclusive.
- abort:
  - in any non-IDLE state, go to IDLE on the next edge and drive all outputs low;
  - the descriptor is discarded;
  - the FIFO is not read again until the following IDLE cycle.
- Back-to-back descriptors: return to IDLE costs one cycle, then the next fetch begins.
- Counter widths:
  - delay counter 24 bits;
  - width counter 16 bits;
  - pulse counter 7 bits;
  - timeout counter TMO_W bits.
  - No counter wraps: each is compared against its limit before decrementing or incrementing.

Decomposition:
- Shared package glitch_pkg holds:
  - state encoding: IDLE, FETCH, RST, ARM, DELAY, GLITCH, GAP;
  - descriptor field offsets and widths;
  - the 48-bit descriptor width.
- The same field constants are used by the Wishbone register block.
- One sub-module, glitch_down_counter: a parameterized-width load/decrement counter with a zero flag, instanced for delay, width and RST/GAP counts.

Test Plan:
- Reset behaviour: descriptor delay=5, width=3, count=0, rst_first=0 pushed, trig pulsed; rst_ni asserted low mid-DELAY → glitch_en never rises and ready=1 after release with an empty FIFO.
- Single pulse: delay=5, width=3, count=0, rst_first=0; trig at cycle T → delay_en high T+1..T+5, glitch_en high T+6..T+8, then ready=1.
- Reset first and repeats: rst_first=1, count=2, width=2, delay=0, GAP_CYCLES=8 → rst_o high for 16 cycles; after trig, 3 glitch_en pulses of 2 cycles, each separated by 8 low cycles.
- Timeout: ARM_TIMEOUT=100, no trig → timeout=1 after 100 ARM cycles, FIFO advances to the next descriptor, and timeout clears on that fetch.
- Abort in GLITCH: width=1000, abort asserted at pulse cycle 10 → glitch_en low on the next edge and busy low.
- Early and zero-width cases: trig during RST is ignored and the next trig is honoured; width=0 gives a 1-cycle pulse; two queued descriptors produce exactly two fifo_re pulses.

Source files
------------

// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch sequencer and the Wishbone register block:
// state encoding, descriptor layout and field helpers.
package glitch_pkg;

   localparam int DESC_W        = 48;
   localparam int DELAY_LSB     = 0;
   localparam int DELAY_W       = 24;
   localparam int WIDTH_LSB     = 24;
   localparam int WIDTH_W       = 16;
   localparam int COUNT_LSB     = 40;
   localparam int COUNT_W       = 7;
   localparam int RST_FIRST_BIT = 47;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      RST,
      ARM,
      DELAY,
      GLITCH,
      GAP
   } state_e;

   // Packed MSB-first so that a cast of the raw FIFO word lines up with the offsets above.
   typedef struct packed {
      logic               rst_first;
      logic [COUNT_W-1:0] count;
      logic [WIDTH_W-1:0] width;
      logic [DELAY_W-1:0] delay;
   } desc_t;

   function automatic logic [WIDTH_W-1:0] width_last(input logic [WIDTH_W-1:0] width);
      return (width == '0) ? '0 : width - 1'b1;
   endfunction

endpackage

// File: rtl/glitch_down_counter.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module glitch_down_counter #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/glitch_sequencer.sv
// Fetches glitch descriptors from the settings FIFO and plays them out as an
// optional target reset, trigger wait, delay and a train of glitch pulses.
module glitch_sequencer
   import glitch_pkg::*;
#(
   parameter int RST_CYCLES  = 16,
   parameter int GAP_CYCLES  = 8,
   parameter int ARM_TIMEOUT = 1000000,
   parameter int TMO_W       = 20
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DESC_W-1:0] fifo_q,
   input  logic              fifo_empty,
   output logic              fifo_re,
   input  logic              trig,
   input  logic              abort,
   output logic              rst_o,
   output logic              glitch_en,
   output logic              delay_en,
   output logic              ready,
   output logic              busy,
   output logic              timeout
);

   localparam int SEQ_MAX = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
   localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
   localparam logic [SEQ_W-1:0] SEQ_RST  = SEQ_W'(RST_CYCLES - 1);
   localparam logic [SEQ_W-1:0] SEQ_GAP  = SEQ_W'(GAP_CYCLES - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARM_TIMEOUT - 1);

   state_e state_q, state_d;
   desc_t  fetched;

   logic [DELAY_W-1:0] dly_cfg_q, dly_cfg_d;
   logic [WIDTH_W-1:0] wid_cfg_q, wid_cfg_d;
   logic [COUNT_W-1:0] cnt_cfg_q, cnt_cfg_d;
   logic [COUNT_W-1:0] pulse_q, pulse_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic               timeout_q, timeout_d;
   logic               rst_q, glitch_q, delay_q;

   logic               dly_load, wid_load, seq_load;
   logic               dly_zero, wid_zero, seq_zero;
   logic [SEQ_W-1:0]   seq_val;

   assign fetched = desc_t'(fifo_q);

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d   = state_q;
      dly_cfg_d = dly_cfg_q;
      wid_cfg_d = wid_cfg_q;
      cnt_cfg_d = cnt_cfg_q;
      pulse_d   = pulse_q;
      timeout_d = timeout_q;
      tmo_d     = '0;
      dly_load  = 1'b0;
      wid_load  = 1'b0;
      seq_load  = 1'b0;
      seq_val   = SEQ_RST;
      fifo_re   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!fifo_empty && rst_ni) begin
               fifo_re = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            dly_cfg_d = fetched.delay;
            wid_cfg_d = fetched.width;
            cnt_cfg_d = fetched.count;
            pulse_d   = '0;
            timeout_d = 1'b0;
            if (fetched.rst_first) begin
               state_d  = RST;
               seq_load = 1'b1;
            end else begin
               state_d = ARM;
            end
         end
         RST: begin
            if (seq_zero) state_d = ARM;
         end
         ARM: begin
            if (trig) begin
               if (dly_cfg_q == '0) begin
                  state_d  = GLITCH;
                  wid_load = 1'b1;
               end else begin
                  state_d  = DELAY;
                  dly_load = 1'b1;
               end
            end else if (tmo_q == TMO_LAST) begin
               // With the timeout disabled the counter simply parks at all-ones.
               tmo_d = tmo_q;
               if (ARM_TIMEOUT != 0) begin
                  timeout_d = 1'b1;
                  state_d   = IDLE;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         DELAY: begin
            if (dly_zero) begin
               state_d  = GLITCH;
               wid_load = 1'b1;
            end
         end
         GLITCH: begin
            if (wid_zero) begin
               if (pulse_q < cnt_cfg_q) begin
                  state_d  = GAP;
                  seq_load = 1'b1;
                  seq_val  = SEQ_GAP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GAP: begin
            if (seq_zero) begin
               state_d  = GLITCH;
               wid_load = 1'b1;
               pulse_d  = pulse_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort && (state_q != IDLE)) state_d = IDLE;
   end

   glitch_down_counter #(.W(DELAY_W)) u_dly_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (dly_load),
      .load_val_i (dly_cfg_q - 1'b1),
      .dec_i      (state_q == DELAY),
      .zero_o     (dly_zero)
   );

   glitch_down_counter #(.W(WIDTH_W)) u_wid_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (wid_load),
      .load_val_i (width_last(wid_cfg_q)),
      .dec_i      (state_q == GLITCH),
      .zero_o     (wid_zero)
   );

   // RST and GAP never overlap, so one counter times both.
   glitch_down_counter #(.W(SEQ_W)) u_seq_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (seq_load),
      .load_val_i (seq_val),
      .dec_i      ((state_q == RST) || (state_q == GAP)),
      .zero_o     (seq_zero)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         pulse_q   <= '0;
         tmo_q     <= '0;
         timeout_q <= 1'b0;
         rst_q     <= 1'b0;
         glitch_q  <= 1'b0;
         delay_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pulse_q   <= pulse_d;
         tmo_q     <= tmo_d;
         timeout_q <= timeout_d;
         rst_q     <= (state_d == RST);
         glitch_q  <= (state_d == GLITCH);
         delay_q   <= (state_d == DELAY);
      end
   end

   // NOTE: descriptor fields carry no reset; FETCH always loads them before any state reads them.
   always_ff @(posedge clk_i) begin
      dly_cfg_q <= dly_cfg_d;
      wid_cfg_q <= wid_cfg_d;
      cnt_cfg_q <= cnt_cfg_d;
   end

   assign rst_o     = rst_q;
   assign glitch_en = glitch_q;
   assign delay_en  = delay_q;
   assign timeout   = timeout_q;
   assign busy      = (state_q != IDLE);
   assign ready     = rst_ni && (state_q == IDLE) && fifo_empty;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Self-checking bench for glitch_sequencer: vector table, hand-built corner
// sequences and randomized descriptors against a timeline model.
module tb_glitch_sequencer;

   localparam int RST_C = 16;
   localparam int GAP_C = 8;
   localparam int TMO   = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [47:0] fifo_q = '0;
   logic        fifo_empty = 1'b1;
   logic        fifo_re;
   logic        trig = 1'b0;
   logic        abort = 1'b0;
   logic        rst_o, glitch_en, delay_en, ready, busy, timeout;

   always #5 clk = ~clk;

   glitch_sequencer #(
      .RST_CYCLES  (RST_C),
      .GAP_CYCLES  (GAP_C),
      .ARM_TIMEOUT (TMO),
      .TMO_W       (20)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .fifo_q     (fifo_q),
      .fifo_empty (fifo_empty),
      .fifo_re    (fifo_re),
      .trig       (trig),
      .abort      (abort),
      .rst_o      (rst_o),
      .glitch_en  (glitch_en),
      .delay_en   (delay_en),
      .ready      (ready),
      .busy       (busy),
      .timeout    (timeout)
   );

   logic [47:0] fifo[$];
   int checks = 0;
   int errors = 0;
   int re_cnt = 0;

   typedef struct {
      bit rf;
      int c, w, d, a;
      bit early;
      int e_rst, e_dly, e_gl, e_pulse, e_lat;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: sample fifo_re before the edge, pop the FIFO model after it.
   task automatic tick();
      logic re_s;
      @(negedge clk);
      re_s = fifo_re;
      if (re_s === 1'b1) re_cnt++;
      @(posedge clk);
      #1;
      if (re_s === 1'b1 && fifo.size() != 0) fifo_q = fifo.pop_front();
      fifo_empty = (fifo.size() == 0);
      #1;
   endtask

   task automatic push(input logic [47:0] desc);
      fifo.push_back(desc);
      fifo_empty = 1'b0;
   endtask

   function automatic logic [47:0] mk(input bit rf, input int c, input int w, input int d);
      return {rf, 7'(c), 16'(w), 24'(d)};
   endfunction

   // Expected {busy, rst_o, delay_en, glitch_en} n cycles after the descriptor was pushed.
   function automatic logic [3:0] model(input int n, input int r, input int t,
                                        input int d, input int w, input int c);
      int k, p, rem;
      if (n == 0) return 4'b0000;
      if (n == 1) return 4'b1000;
      if (n <= 1 + r) return 4'b1100;
      if (n <= t) return 4'b1000;
      if (n <= t + d) return 4'b1010;
      k   = n - t - d - 1;
      p   = k / (w + GAP_C);
      rem = k % (w + GAP_C);
      if (p > c) return 4'b0000;
      if (rem < w) return 4'b1001;
      if (p < c) return 4'b1000;
      return 4'b0000;
   endfunction

   task automatic run_desc(input string tag, input logic [47:0] desc, input int a, input bit early,
                           output int n_rst, output int n_dly, output int n_gl,
                           output int n_pulse, output int lat);
      int r, t, d, w, c, first_gl;
      logic [3:0] exp_v, act_v;
      logic prev_gl;
      r  = desc[47] ? RST_C : 0;
      d  = int'(desc[23:0]);
      w  = (desc[39:24] == 16'd0) ? 1 : int'(desc[39:24]);
      c  = int'(desc[46:40]);
      t  = 2 + r + a;
      n_rst = 0; n_dly = 0; n_gl = 0; n_pulse = 0;
      first_gl = -1;
      prev_gl  = 1'b0;
      push(desc);
      for (int n = 1; n <= 3000; n++) begin
         trig = ((n - 1) == t) || (early && (r > 0) && ((n - 1) == 2));
         tick();
         trig = 1'b0;
         exp_v = model(n, r, t, d, w, c);
         act_v = {busy, rst_o, delay_en, glitch_en};
         check($sformatf("%s n=%0d {busy,rst,dly,gl}", tag, n), int'(act_v), int'(exp_v));
         n_rst += int'(rst_o);
         n_dly += int'(delay_en);
         n_gl  += int'(glitch_en);
         if (glitch_en && !prev_gl) begin
            n_pulse++;
            if (first_gl < 0) first_gl = n;
         end
         prev_gl = glitch_en;
         if (exp_v == 4'b0000) break;
      end
      lat = first_gl - t;
   endtask

   initial begin
      int n_rst, n_dly, n_gl, n_pulse, lat, re0;
      bit gl_seen;

      vecs[0] = '{rf:0, c:0, w:3, d:5, a:4, early:0, e_rst:0,  e_dly:5, e_gl:3, e_pulse:1, e_lat:6};
      vecs[1] = '{rf:1, c:2, w:2, d:0, a:2, early:1, e_rst:16, e_dly:0, e_gl:6, e_pulse:3, e_lat:1};
      vecs[2] = '{rf:0, c:0, w:0, d:0, a:0, early:0, e_rst:0,  e_dly:0, e_gl:1, e_pulse:1, e_lat:1};
      vecs[3] = '{rf:0, c:1, w:1, d:2, a:7, early:0, e_rst:0,  e_dly:2, e_gl:2, e_pulse:2, e_lat:3};
      vecs[4] = '{rf:1, c:0, w:4, d:3, a:0, early:1, e_rst:16, e_dly:3, e_gl:4, e_pulse:1, e_lat:4};

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("reset outputs", int'({fifo_re, rst_o, glitch_en, delay_en, ready, busy, timeout}), 0);
      rst_n = 1'b1;
      tick();
      check("idle ready", int'(ready), 1);
      check("idle busy", int'(busy), 0);

      // Table-driven descriptors
      foreach (vecs[i]) begin
         run_desc($sformatf("vec%0d", i), mk(vecs[i].rf, vecs[i].c, vecs[i].w, vecs[i].d),
                  vecs[i].a, vecs[i].early, n_rst, n_dly, n_gl, n_pulse, lat);
         check($sformatf("vec%0d rst cycles", i), n_rst, vecs[i].e_rst);
         check($sformatf("vec%0d delay cycles", i), n_dly, vecs[i].e_dly);
         check($sformatf("vec%0d glitch cycles", i), n_gl, vecs[i].e_gl);
         check($sformatf("vec%0d pulses", i), n_pulse, vecs[i].e_pulse);
         check($sformatf("vec%0d trig latency", i), lat, vecs[i].e_lat);
         check($sformatf("vec%0d ready after", i), int'(ready), 1);
      end

      // Reset asserted in the middle of DELAY
      push(mk(0, 0, 3, 5));
      for (int n = 1; n <= 4; n++) begin
         trig = ((n - 1) == 2);
         tick();
         trig = 1'b0;
      end
      check("mid-delay delay_en", int'(delay_en), 1);
      rst_n = 1'b0;
      tick();
      check("mid-delay reset outputs", int'({rst_o, glitch_en, delay_en, busy}), 0);
      rst_n = 1'b1;
      gl_seen = 1'b0;
      repeat (12) begin
         tick();
         gl_seen |= glitch_en;
      end
      check("mid-delay glitch never", int'(gl_seen), 0);
      check("mid-delay ready", int'(ready), 1);

      // Arm timeout with a second descriptor queued behind it
      re0 = re_cnt;
      push(mk(0, 0, 3, 5));
      push(mk(0, 0, 2, 1));
      for (int n = 1; n <= 101; n++) tick();
      check("tmo last arm busy", int'(busy), 1);
      check("tmo last arm flag", int'(timeout), 0);
      tick();
      check("tmo flag set", int'(timeout), 1);
      check("tmo back to idle", int'(busy), 0);
      tick();
      tick();
      check("tmo cleared on fetch", int'(timeout), 0);
      check("tmo next desc armed", int'(busy), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort in arm busy", int'(busy), 0);
      repeat (3) tick();
      check("two fetches", re_cnt - re0, 2);
      check("tmo ready", int'(ready), 1);

      // Abort ten cycles into a long pulse
      push(mk(0, 0, 1000, 0));
      for (int n = 1; n <= 12; n++) begin
         trig = ((n - 1) == 2);
         tick();
         trig = 1'b0;
      end
      check("abort pre glitch_en", int'(glitch_en), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort glitch_en", int'(glitch_en), 0);
      check("abort busy", int'(busy), 0);
      tick();
      check("abort ready", int'(ready), 1);

      // Randomized descriptors against the timeline model
      for (int i = 0; i < 25; i++) begin
         run_desc($sformatf("rnd%0d", i),
                  mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 20))),
                  int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)),
                  n_rst, n_dly, n_gl, n_pulse, lat);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
